// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch-and-decode front end of the 4-bit microcontroller.
// It holds the program counter and registers each program-memory byte into the
// instruction register. It decodes that byte into the computational unit's control
// word, and resolves unconditional and zero-flag-conditional jumps.
// Optional feature macro: DELAY_SLOT_EN. When it is defined, the byte fetched after
// a taken jump executes as a delay slot instead of being squashed.
module instr_fetch_decode (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       r_eq_0,
  output logic [7:0] pm_addr,
  output logic [3:0] ir_nibble,
  output logic [3:0] source_sel,
  output logic [8:0] reg_en,
  output logic       x_sel,
  output logic       y_sel,
  output logic       i_sel
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   ir_q;
  logic [7:0]   ir_pc_q;
  logic         jump_taken_s;
  logic [2:0]   move_ddd_s;
  logic [2:0]   move_sss_s;
  logic         dm_access_s;

  // Register-enable bit for a destination field. The i post-increment that goes
  // with a data-memory access is added by the caller.
  function automatic logic [8:0] dest_en(input logic [2:0] ddd);
    logic [8:0] en;
    case (ddd)
      3'd0:    en = 9'h001;
      3'd1:    en = 9'h002;
      3'd2:    en = 9'h004;
      3'd3:    en = 9'h008;
      3'd4:    en = 9'h100;
      3'd5:    en = 9'h020;
      3'd6:    en = 9'h040;
      3'd7:    en = 9'h080;
      default: en = 9'h000;
    endcase
    return en;
  endfunction

  assign pm_addr    = pc_q;
  assign move_ddd_s = ir_q[5:3];
  assign move_sss_s = ir_q[2:0];
  // A move that reads or writes data memory also post-increments i.
  assign dm_access_s = (move_sss_s == 3'd7) || (move_ddd_s == 3'd7);

  // Decode the held instruction into the control word; idle outside RUN and for jumps.
  always_comb begin
    reg_en       = 9'h000;
    source_sel   = 4'hF;
    x_sel        = 1'b0;
    y_sel        = 1'b0;
    i_sel        = 1'b0;
    ir_nibble    = 4'h0;
    jump_taken_s = 1'b0;
    if (state_q == ST_RUN) begin
      casez (ir_q)
        8'b0???????: begin
          // Load immediate nibble
          source_sel = 4'd8;
          ir_nibble  = ir_q[3:0];
          reg_en     = dest_en(ir_q[6:4]) | ((ir_q[6:4] == 3'd7) ? 9'h040 : 9'h000);
          i_sel      = (ir_q[6:4] == 3'd7);
        end
        8'b10??????: begin
          // Register move; same source and destination selects the input pins
          source_sel = (move_sss_s == move_ddd_s) ? 4'd9 : {1'b0, move_sss_s};
          ir_nibble  = ir_q[3:0];
          reg_en     = dest_en(move_ddd_s) | (dm_access_s ? 9'h040 : 9'h000);
          // A load of i itself overrides the post-increment mode
          i_sel      = dm_access_s && (move_ddd_s != 3'd6);
        end
        8'b110?????: begin
          // ALU operation writes r and the zero flag
          reg_en    = 9'h010;
          x_sel     = ir_q[4];
          y_sel     = ir_q[3];
          ir_nibble = ir_q[3:0];
        end
        8'b1110????: begin
          jump_taken_s = 1'b1;
        end
        8'b1111????: begin
          jump_taken_s = ~r_eq_0;
        end
        default: begin
          jump_taken_s = 1'b0;
        end
      endcase
    end else begin
      jump_taken_s = 1'b0;
    end
  end

  // Next program counter and fetch state. The jump target stays in the jump's own page.
  always_comb begin
    pc_d    = jump_taken_s ? {ir_pc_q[7:4], ir_q[3:0]} : (pc_q + 8'd1);
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN: begin
`ifdef DELAY_SLOT_EN
        state_d = ST_RUN;
`else
        state_d = jump_taken_s ? ST_FLUSH : ST_RUN;
`endif
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // Fetch pipeline and state registers; reset aborts any jump or flush in progress.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      pc_q    <= 8'h00;
      ir_q    <= 8'h00;
      ir_pc_q <= 8'h00;
      state_q <= ST_RESET;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= pm_data;
      ir_pc_q <= pc_q;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode. It runs random and directed programs against an
// instruction-stream model. The model tracks the fetch address, the address being
// executed, and whether the current slot is a bubble.
module tb_instr_fetch_decode;

  logic       clk;
  logic       sync_reset;
  logic       r_eq_0;
  logic [7:0] pm_data;
  logic [7:0] pm_addr;
  logic [3:0] ir_nibble;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       x_sel;
  logic       y_sel;
  logic       i_sel;

  logic [7:0] mem [256];
  int         chk_cnt = 0;
  int         err_cnt = 0;

  // Model state: next fetch address, address of the instruction being decoded,
  // and whether that slot holds a real instruction.
  logic [7:0] m_pc;
  logic [7:0] m_cur;
  logic       m_valid;

  localparam logic [19:0] IDLE = {9'h000, 4'hF, 3'b000, 4'h0};

  assign pm_data = mem[pm_addr];

  instr_fetch_decode dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .pm_data    (pm_data),
    .r_eq_0     (r_eq_0),
    .pm_addr    (pm_addr),
    .ir_nibble  (ir_nibble),
    .source_sel (source_sel),
    .reg_en     (reg_en),
    .x_sel      (x_sel),
    .y_sel      (y_sel),
    .i_sel      (i_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [19:0] obs, input logic [19:0] exp_v);
    chk_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp_v);
    end
  endtask

  function automatic logic [8:0] dest_mask(input int d);
    logic [8:0] tbl [8];
    tbl = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h100, 9'h020, 9'h040, 9'h080};
    return tbl[d];
  endfunction

  // Expected control word {reg_en, source_sel, x_sel, y_sel, i_sel, ir_nibble} for a byte.
  function automatic logic [19:0] model_ctrl(input logic [7:0] b);
    int v, d, s;
    logic [8:0] en;
    logic [3:0] src;
    logic xs, ys, is_i;
    v = int'(b);
    en = 9'h000; src = 4'hF; xs = 1'b0; ys = 1'b0; is_i = 1'b0;
    if (v < 128) begin
      d   = (v / 16) % 8;
      en  = dest_mask(d);
      src = 4'd8;
      if (d == 7) begin en = en | 9'h040; is_i = 1'b1; end
    end else if (v < 192) begin
      d   = (v / 8) % 8;
      s   = v % 8;
      src = (s == d) ? 4'd9 : 4'(s);
      en  = dest_mask(d);
      if (s == 7 || d == 7) begin en = en | 9'h040; is_i = (d != 6); end
    end else if (v < 224) begin
      en = 9'h010;
      xs = ((v / 16) % 2) == 1;
      ys = ((v / 8) % 2) == 1;
    end else begin
      return IDLE;
    end
    return {en, src, xs, ys, is_i, b[3:0]};
  endfunction

  function automatic logic model_taken(input logic [7:0] b, input logic r);
    return (b >= 8'hE0) && ((b < 8'hF0) || !r);
  endfunction

  // mode 1 fills with non-jump bytes only, mode 0 with anything.
  task automatic fill(input int mode);
    for (int a = 0; a < 256; a++)
      mem[a] = (mode != 0) ? 8'($urandom_range(0, 223)) : 8'($urandom);
  endtask

  // Assert reset mid-cycle, check the immediate idle response, release after an edge.
  task automatic do_reset();
    sync_reset = 1'b1;
    #1;
    check_val("rst_ctrl", {reg_en, source_sel, x_sel, y_sel, i_sel, ir_nibble}, IDLE);
    check_val("rst_pm_addr", {12'h000, pm_addr}, 20'h00000);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    m_pc = 8'h00; m_cur = 8'h00; m_valid = 1'b0;
  endtask

  // One clock cycle: drive the zero flag, compare outputs, advance the model.
  task automatic run_cycle(input logic rv);
    logic [19:0] e;
    logic [7:0]  tgt;
    r_eq_0 = rv;
    #2;
    e = m_valid ? model_ctrl(mem[m_cur]) : IDLE;
    check_val("ctrl", {reg_en, source_sel, x_sel, y_sel, i_sel, ir_nibble}, e);
    check_val("pm_addr", {12'h000, pm_addr}, {12'h000, m_pc});
    if (m_valid && model_taken(mem[m_cur], rv)) begin
      tgt   = {m_cur[7:4], mem[m_cur][3:0]};
      m_cur = m_pc;
      m_pc  = tgt;
`ifdef DELAY_SLOT_EN
      m_valid = 1'b1;
`else
      m_valid = 1'b0;
`endif
    end else begin
      m_cur   = m_pc;
      m_pc    = m_pc + 8'd1;
      m_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    sync_reset = 1'b0;
    r_eq_0     = 1'b0;
    m_pc = 8'h00; m_cur = 8'h00; m_valid = 1'b0;
    fill(1);
    #2;

    // Reset release, load at 0, unconditional jump at 3
    mem[0] = 8'h05; mem[3] = 8'hE9; mem[4] = 8'h12;
    do_reset();
    repeat (12) run_cycle(1'($urandom));

    // ALU followed by Jnz, with both zero-flag values
    for (int r = 0; r < 2; r++) begin
      fill(1);
      mem[0] = 8'hD3; mem[1] = 8'hF0;
      do_reset();
      run_cycle(1'b0);
      run_cycle(1'b0);
      run_cycle(r[0]);
      repeat (6) run_cycle(1'($urandom));
    end

    // Data-memory moves
    fill(1);
    mem[0] = 8'hBF; mem[1] = 8'hB7;
    do_reset();
    repeat (4) run_cycle(1'($urandom));

    // Jump and fall-through at the top address
    for (int k = 0; k < 2; k++) begin
      fill(1);
      mem[255] = (k == 0) ? 8'hE3 : 8'h21;
      do_reset();
      repeat (262) run_cycle(1'($urandom));
    end

    // Reset while the post-jump byte is being squashed, then restart
    fill(1);
    mem[3] = 8'hE9;
    do_reset();
    repeat (5) run_cycle(1'b1);
    do_reset();
    repeat (8) run_cycle(1'($urandom));

    // Fully random programs
    repeat (8) begin
      fill(0);
      do_reset();
      repeat (200) run_cycle(1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
